// File: rtl/dbus_pkg.sv
// Shared types for the data-bus arbiter: FSM states and grant-side identifiers.
package dbus_pkg;

  typedef enum logic [1:0] {
    ST_ARB       = 2'd0,
    ST_CPU_RD    = 2'd1,
    ST_HOST_DONE = 2'd2
  } dbus_state_e;

  typedef enum logic {
    GNT_CPU  = 1'b0,
    GNT_HOST = 1'b1
  } gnt_side_e;

endpackage

// File: rtl/dbus_rr_pick.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to the side not granted last.
module dbus_rr_pick
  import dbus_pkg::*;
(
  input  logic      req_cpu,
  input  logic      req_host,
  input  gnt_side_e last,
  output logic      gnt_cpu,
  output logic      gnt_host
);

  always_comb begin
    gnt_cpu  = req_cpu  & (~req_host | (last == GNT_HOST));
    gnt_host = req_host & (~req_cpu  | (last == GNT_CPU));
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Shares one synchronous single-port data RAM between the core data port and a host/DMA port,
// generating core stalls and a saturating stall-cycle counter.
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned STALL_W = 16
) (
  input  logic               CLK,
  input  logic               RES,
  input  logic [31:0]        CPU_DADDR,
  input  logic [31:0]        CPU_DATAO,
  input  logic [3:0]         CPU_BE,
  input  logic               CPU_WR,
  input  logic               CPU_RD,
  output logic [31:0]        CPU_DATAI,
  output logic               CPU_HLT,
  input  logic               EXT_HLT,
  input  logic               HOST_REQ,
  input  logic               HOST_WE,
  input  logic [31:0]        HOST_ADDR,
  input  logic [31:0]        HOST_WDATA,
  input  logic [3:0]         HOST_BE,
  output logic               HOST_ACK,
  output logic [31:0]        HOST_RDATA,
  output logic               MEM_EN,
  output logic               MEM_WE,
  output logic [3:0]         MEM_BE,
  output logic [ADDR_W-1:0]  MEM_A,
  output logic [31:0]        MEM_D,
  input  logic [31:0]        MEM_Q,
  output logic [STALL_W-1:0] STALLS
);

  dbus_state_e        state_q, state_d;
  gnt_side_e          last_q, last_d;
  logic [STALL_W-1:0] stalls_q;
  logic [31:0]        cpu_rdata_q;
  logic [ADDR_W-1:0]  mem_a_q;
  logic [31:0]        mem_d_q;
  logic [3:0]         mem_be_q;

  logic cpu_req, in_arb, gnt_cpu, gnt_host, cpu_done;
  logic unused_addr_bits;

  assign cpu_req = CPU_WR | CPU_RD;
  assign in_arb  = (state_q == ST_ARB) & ~RES;
  assign unused_addr_bits = ^{CPU_DADDR[31:ADDR_W+2], CPU_DADDR[1:0],
                              HOST_ADDR[31:ADDR_W+2], HOST_ADDR[1:0]};

  dbus_rr_pick u_pick (
    .req_cpu  (cpu_req  & in_arb),
    .req_host (HOST_REQ & in_arb),
    .last     (last_q),
    .gnt_cpu  (gnt_cpu),
    .gnt_host (gnt_host)
  );

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q     <= ST_ARB;
      last_q      <= GNT_HOST;
      stalls_q    <= '0;
      cpu_rdata_q <= '0;
      mem_a_q     <= '0;
      mem_d_q     <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cpu_rdata_q <= CPU_DATAI;
      mem_a_q     <= MEM_A;
      mem_d_q     <= MEM_D;
      mem_be_q    <= MEM_BE;
      if (CPU_HLT && (stalls_q != '1)) stalls_q <= stalls_q + STALL_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ST_ARB: begin
        if (gnt_cpu) begin
          last_d = GNT_CPU;
          if (!CPU_WR) state_d = ST_CPU_RD;
        end else if (gnt_host) begin
          last_d  = GNT_HOST;
          state_d = ST_HOST_DONE;
        end
      end
      ST_CPU_RD, ST_HOST_DONE: state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  // Idle cycles re-present the held bus registers so MEM_A/MEM_D/MEM_BE never glitch.
  always_comb begin
    MEM_EN     = 1'b0;
    MEM_WE     = 1'b0;
    MEM_BE     = mem_be_q;
    MEM_A      = mem_a_q;
    MEM_D      = mem_d_q;
    HOST_ACK   = 1'b0;
    HOST_RDATA = MEM_Q;
    CPU_DATAI  = cpu_rdata_q;
    cpu_done   = 1'b0;
    if (!RES) begin
      unique case (state_q)
        ST_ARB: begin
          if (gnt_cpu) begin
            MEM_EN   = 1'b1;
            MEM_WE   = CPU_WR;
            MEM_BE   = CPU_BE;
            MEM_A    = CPU_DADDR[ADDR_W+1:2];
            MEM_D    = CPU_DATAO;
            cpu_done = CPU_WR;
          end else if (gnt_host) begin
            MEM_EN = 1'b1;
            MEM_WE = HOST_WE;
            MEM_BE = HOST_BE;
            MEM_A  = HOST_ADDR[ADDR_W+1:2];
            MEM_D  = HOST_WDATA;
          end
        end
        ST_CPU_RD: begin
          CPU_DATAI = MEM_Q;
          cpu_done  = 1'b1;
        end
        ST_HOST_DONE: HOST_ACK = 1'b1;
        default: ;
      endcase
    end
    CPU_HLT = RES | EXT_HLT | (cpu_req & ~cpu_done);
  end

  assign STALLS = stalls_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed and randomized checks of dbus_arbiter against a transaction-level memory/latency model.
module tb_dbus_arbiter;

  localparam int ADDR_W  = 10;
  localparam int STALL_W = 4;
  localparam int STALL_MAX = (1 << STALL_W) - 1;

  logic               CLK = 1'b0;
  logic               RES;
  logic [31:0]        CPU_DADDR, CPU_DATAO, CPU_DATAI;
  logic [3:0]         CPU_BE;
  logic               CPU_WR, CPU_RD, CPU_HLT, EXT_HLT;
  logic               HOST_REQ, HOST_WE, HOST_ACK;
  logic [31:0]        HOST_ADDR, HOST_WDATA, HOST_RDATA;
  logic [3:0]         HOST_BE;
  logic               MEM_EN, MEM_WE;
  logic [3:0]         MEM_BE;
  logic [ADDR_W-1:0]  MEM_A;
  logic [31:0]        MEM_D, MEM_Q;
  logic [STALL_W-1:0] STALLS;

  dbus_arbiter #(.ADDR_W(ADDR_W), .STALL_W(STALL_W)) dut (
    .CLK(CLK), .RES(RES),
    .CPU_DADDR(CPU_DADDR), .CPU_DATAO(CPU_DATAO), .CPU_BE(CPU_BE),
    .CPU_WR(CPU_WR), .CPU_RD(CPU_RD), .CPU_DATAI(CPU_DATAI), .CPU_HLT(CPU_HLT),
    .EXT_HLT(EXT_HLT),
    .HOST_REQ(HOST_REQ), .HOST_WE(HOST_WE), .HOST_ADDR(HOST_ADDR),
    .HOST_WDATA(HOST_WDATA), .HOST_BE(HOST_BE), .HOST_ACK(HOST_ACK), .HOST_RDATA(HOST_RDATA),
    .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_BE(MEM_BE), .MEM_A(MEM_A),
    .MEM_D(MEM_D), .MEM_Q(MEM_Q), .STALLS(STALLS)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = d[8*b +: 8];
    return old;
  endfunction

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // Synchronous single-port RAM seen by the arbiter
  logic        tb_init;
  logic [31:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge CLK) begin
    if (tb_init) begin
      for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= init_val(i);
    end else if (MEM_EN) begin
      if (MEM_WE) ram[MEM_A] <= merge(ram[MEM_A], MEM_D, MEM_BE);
      else        MEM_Q <= ram[MEM_A];
    end
  end

  // Reference state
  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
  int  tests = 0, fails = 0;
  int  stall_model = 0;
  bit  model_valid = 0;
  int  cpu_run = 0, host_run = 0;
  bit  s_res, s_hlt, s_cpu_done, s_host_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    logic [9:0] idx;
    @(negedge CLK);
    s_res = RES; s_hlt = CPU_HLT;
    s_cpu_done = 1'b0; s_host_done = 1'b0;
    if (RES) begin
      cpu_run = 0; host_run = 0;
    end else begin
      if (model_valid) check("stalls", 32'(STALLS), 32'(stall_model));
      if ((CPU_WR || CPU_RD) && !CPU_HLT) begin
        s_cpu_done = 1'b1;
        idx = CPU_DADDR[11:2];
        if (CPU_WR) begin
          check("cpu_wr_strobe", {30'd0, MEM_EN, MEM_WE}, 32'd3);
          check("cpu_wr_addr", 32'(MEM_A), 32'(idx));
          check("cpu_wr_wait", 32'(cpu_run <= 2), 32'd1);
          ref_mem[idx] = merge(ref_mem[idx], CPU_DATAO, CPU_BE);
        end else begin
          check("cpu_rd_data", CPU_DATAI, ref_mem[idx]);
          check("cpu_rd_wait", 32'(cpu_run <= 3), 32'd1);
        end
        cpu_run = 0;
      end else if ((CPU_WR || CPU_RD) && !EXT_HLT) cpu_run++;
      else if (!(CPU_WR || CPU_RD)) cpu_run = 0;

      if (HOST_ACK) begin
        s_host_done = 1'b1;
        check("host_ack_req", 32'(HOST_REQ), 32'd1);
        idx = HOST_ADDR[11:2];
        if (HOST_WE) ref_mem[idx] = merge(ref_mem[idx], HOST_WDATA, HOST_BE);
        else check("host_rdata", HOST_RDATA, ref_mem[idx]);
        check("host_wait", 32'(host_run <= 3), 32'd1);
        host_run = 0;
      end else if (HOST_REQ) host_run++;
      else host_run = 0;
    end
  endtask

  task automatic advance();
    @(posedge CLK);
    if (s_res) begin
      stall_model = 0; model_valid = 1;
    end else if (model_valid && s_hlt && stall_model != STALL_MAX) stall_model++;
    #1;
  endtask

  task automatic set_idle();
    CPU_WR = 0; CPU_RD = 0; HOST_REQ = 0; EXT_HLT = 0;
  endtask

  initial begin
    logic [31:0] a;
    int r;
    for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = init_val(i);
    RES = 1; tb_init = 1; set_idle();
    CPU_DADDR = 0; CPU_DATAO = 0; CPU_BE = 4'hF;
    HOST_WE = 0; HOST_ADDR = 0; HOST_WDATA = 0; HOST_BE = 4'hF;

    // Reset behaviour, including a request presented during reset
    sample();
    check("rst_mem_en", 32'(MEM_EN), 32'd0);
    check("rst_ack", 32'(HOST_ACK), 32'd0);
    check("rst_hlt", 32'(CPU_HLT), 32'd1);
    advance();
    tb_init = 0; CPU_WR = 1; HOST_REQ = 1;
    sample();
    check("rst_req_en", {30'd0, MEM_EN, MEM_WE}, 32'd0);
    check("rst_req_ack", 32'(HOST_ACK), 32'd0);
    advance();
    RES = 0; set_idle();
    sample();
    check("post_rst_stalls", 32'(STALLS), 32'd0);
    check("post_rst_hlt", 32'(CPU_HLT), 32'd0);
    check("post_rst_en", 32'(MEM_EN), 32'd0);
    advance();

    // Uncontended CPU write: one cycle, no stall
    CPU_WR = 1; CPU_DADDR = 32'h10; CPU_DATAO = 32'hDEADBEEF; CPU_BE = 4'hF;
    sample();
    check("wr_en_we", {30'd0, MEM_EN, MEM_WE}, 32'd3);
    check("wr_a", 32'(MEM_A), 32'd4);
    check("wr_d", MEM_D, 32'hDEADBEEF);
    check("wr_hlt", 32'(CPU_HLT), 32'd0);
    advance();
    CPU_WR = 0;

    // Uncontended CPU read: two cycles
    CPU_RD = 1;
    sample();
    check("rd0_hlt", 32'(CPU_HLT), 32'd1);
    check("rd0_en_we", {30'd0, MEM_EN, MEM_WE}, 32'd2);
    check("rd0_a", 32'(MEM_A), 32'd4);
    advance();
    sample();
    check("rd1_hlt", 32'(CPU_HLT), 32'd0);
    check("rd1_data", CPU_DATAI, 32'hDEADBEEF);
    check("rd1_en", 32'(MEM_EN), 32'd0);
    advance();
    CPU_RD = 0; CPU_DADDR = 32'h0000_0FFC;
    sample();
    check("idle_datai_hold", CPU_DATAI, 32'hDEADBEEF);
    check("idle_a_hold", 32'(MEM_A), 32'd4);
    check("idle_hlt", 32'(CPU_HLT), 32'd0);
    advance();

    // Simultaneous CPU read and host read after reset: CPU first
    RES = 1; sample(); advance(); RES = 0;
    CPU_RD = 1; CPU_DADDR = 32'h10;
    HOST_REQ = 1; HOST_WE = 0; HOST_ADDR = 32'hABC0_0010;
    sample();
    check("both0_en_we", {30'd0, MEM_EN, MEM_WE}, 32'd2);
    check("both0_hlt", 32'(CPU_HLT), 32'd1);
    check("both0_ack", 32'(HOST_ACK), 32'd0);
    advance();
    sample();
    check("both1_hlt", 32'(CPU_HLT), 32'd0);
    check("both1_data", CPU_DATAI, 32'hDEADBEEF);
    check("both1_en", 32'(MEM_EN), 32'd0);
    check("both1_ack", 32'(HOST_ACK), 32'd0);
    advance();
    CPU_RD = 0;
    sample();
    check("both2_en_we", {30'd0, MEM_EN, MEM_WE}, 32'd2);
    check("both2_a", 32'(MEM_A), 32'd4);
    check("both2_ack", 32'(HOST_ACK), 32'd0);
    advance();
    sample();
    check("both3_ack", 32'(HOST_ACK), 32'd1);
    check("both3_rdata", HOST_RDATA, 32'hDEADBEEF);
    check("both3_en", 32'(MEM_EN), 32'd0);
    advance();
    HOST_REQ = 0;

    // Continuous host writes against pending CPU writes: C, H, ack, C, H, ack ...
    CPU_WR = 1; CPU_DADDR = 32'h30; CPU_DATAO = $urandom; CPU_BE = 4'hF;
    HOST_REQ = 1; HOST_WE = 1; HOST_ADDR = 32'h20; HOST_WDATA = $urandom; HOST_BE = 4'(($urandom_range(1, 15)));
    for (int k = 0; k < 9; k++) begin
      sample();
      check("alt_en", 32'(MEM_EN), 32'((k % 3) != 2));
      check("alt_hlt", 32'(CPU_HLT), 32'((k % 3) != 0));
      check("alt_ack", 32'(HOST_ACK), 32'((k % 3) == 2));
      if ((k % 3) == 0) check("alt_a_cpu", 32'(MEM_A), 32'd12);
      if ((k % 3) == 1) check("alt_a_host", 32'(MEM_A), 32'd8);
      advance();
      if ((k % 3) == 0) CPU_DATAO = $urandom;
      if ((k % 3) == 2) HOST_WDATA = $urandom;
    end
    set_idle();

    // Reset while in the CPU read-data cycle
    CPU_RD = 1; CPU_DADDR = 32'h30;
    sample();
    check("rrd_issue_en", 32'(MEM_EN), 32'd1);
    advance();
    RES = 1;
    sample();
    check("rrd_rst_en", 32'(MEM_EN), 32'd0);
    check("rrd_rst_hlt", 32'(CPU_HLT), 32'd1);
    advance();
    RES = 0; CPU_RD = 0;
    sample();
    check("rrd_post_en", 32'(MEM_EN), 32'd0);
    check("rrd_post_ack", 32'(HOST_ACK), 32'd0);
    check("rrd_post_stalls", 32'(STALLS), 32'd0);
    advance();
    CPU_WR = 1; CPU_DADDR = 32'h40; CPU_DATAO = $urandom;
    sample();
    check("rrd_arb_wr", {30'd0, MEM_EN, MEM_WE}, 32'd3);
    check("rrd_arb_hlt", 32'(CPU_HLT), 32'd0);
    advance();
    CPU_WR = 0;

    // Reset while the host completion is due: no acknowledge
    HOST_REQ = 1; HOST_WE = 0; HOST_ADDR = 32'h40;
    sample();
    check("hrst_grant_en", 32'(MEM_EN), 32'd1);
    advance();
    RES = 1;
    sample();
    check("hrst_ack", 32'(HOST_ACK), 32'd0);
    advance();
    RES = 0; HOST_REQ = 0;
    sample();
    check("hrst_post_ack", 32'(HOST_ACK), 32'd0);
    advance();

    // External halt alone, then 20 blocked write cycles: counter saturates
    EXT_HLT = 1;
    sample();
    check("ext_hlt_noreq", 32'(CPU_HLT), 32'd1);
    advance();
    CPU_WR = 1; CPU_DADDR = 32'h44; CPU_DATAO = $urandom;
    for (int k = 0; k < 20; k++) begin
      sample();
      check("ext_hlt_blk", 32'(CPU_HLT), 32'd1);
      advance();
    end
    EXT_HLT = 0;
    sample();
    check("stalls_sat", 32'(STALLS), 32'(STALL_MAX));
    check("ext_release_hlt", 32'(CPU_HLT), 32'd0);
    advance();
    CPU_WR = 0;

    // Randomized traffic from both sides
    for (int n = 0; n < 400; n++) begin
      sample();
      advance();
      if (s_cpu_done || !(CPU_WR || CPU_RD)) begin
        r = $urandom_range(0, 9);
        CPU_WR = (r < 3) || (r == 9);
        CPU_RD = (r >= 3 && r < 6) || (r == 9);
        a = $urandom; a[11:2] = 10'($urandom_range(0, 15)); a[1:0] = 2'b00;
        CPU_DADDR = a; CPU_DATAO = $urandom; CPU_BE = 4'($urandom_range(0, 15));
      end
      if (s_host_done || !HOST_REQ) begin
        HOST_REQ = ($urandom_range(0, 2) != 0);
        HOST_WE = 1'($urandom_range(0, 1));
        a = $urandom; a[11:2] = 10'($urandom_range(0, 15)); a[1:0] = 2'b00;
        HOST_ADDR = a; HOST_WDATA = $urandom; HOST_BE = 4'($urandom_range(0, 15));
      end
    end
    set_idle();
    sample(); advance();
    sample(); advance();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
